// File: rtl/ucsbece154b_defines_pkg.sv
// rtl/ucsbece154b_defines_pkg.sv - shared opcode and 2-bit counter definitions for the branch predictor
package ucsbece154b_defines;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [1:0] CTR_RESET = WNT;

endpackage

// File: rtl/ucsbece154b_sat_counter2.sv
// rtl/ucsbece154b_sat_counter2.sv - 2-bit saturating counter next-state function
module ucsbece154b_sat_counter2
    import ucsbece154b_defines::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] next_cnt
);

    // step toward taken/not-taken, holding at the strong ends
    always_comb begin
        next_cnt = cnt;
        case (cnt)
            SNT: next_cnt = taken ? WNT : SNT;
            WNT: next_cnt = taken ? WT  : SNT;
            WT:  next_cnt = taken ? ST  : WNT;
            ST:  next_cnt = taken ? ST  : WT;
            default: next_cnt = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/ucsbece154b_branch_predictor.sv
// rtl/ucsbece154b_branch_predictor.sv - BTB + PHT branch predictor; gshare indexing when UCSBECE154B_GSHARE_EN is defined
module ucsbece154b_branch_predictor
    import ucsbece154b_defines::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             pc_i,
    output logic                    BranchTaken_o,
    output logic [31:0]             BTBtarget_o,
    output logic [NUM_GHR_BITS-1:0] PHTaddr_o,
    input  logic [6:0]              op_i,
    input  logic [31:0]             PCE_i,
    input  logic [31:0]             PCTargetE_i,
    input  logic [NUM_GHR_BITS-1:0] PHTaddrE_i,
    input  logic                    BranchTakenE_i
);

    localparam int IDX_W = $clog2(NUM_BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int G     = NUM_GHR_BITS;
    localparam int PHT_N = 2 ** G;

    logic [NUM_BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]           btb_tag    [NUM_BTB_ENTRIES];
    logic [31:0]                btb_target [NUM_BTB_ENTRIES];
    logic                       btb_is_j   [NUM_BTB_ENTRIES];
    logic [1:0]                 pht        [PHT_N];
    logic [1:0]                 pht_next   [PHT_N];

    logic             is_branch;
    logic             is_jump;
    logic             train_btb;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] e_idx;
    logic [G-1:0]     pht_idx_f;
    logic             hit;
    logic             unused_pc_bits;

    assign is_branch      = (op_i == OP_BRANCH);
    assign is_jump        = (op_i == OP_JAL) || (op_i == OP_JALR);
    assign train_btb      = is_branch || is_jump;
    assign f_idx          = pc_i[IDX_W+1:2];
    assign e_idx          = PCE_i[IDX_W+1:2];
    assign unused_pc_bits = ^{pc_i[1:0], PCE_i[1:0]};

`ifdef UCSBECE154B_GSHARE_EN
    logic [G-1:0] ghr;

    // global history shifts only on resolved conditional branches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (is_branch) begin
            ghr <= {ghr[G-2:0], BranchTakenE_i};
        end
    end

    assign pht_idx_f = pc_i[G+1:2] ^ ghr;
`else
    assign pht_idx_f = pc_i[G+1:2];
`endif

    // valid bits need reset so every lookup misses after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_valid <= '0;
        end else if (train_btb) begin
            btb_valid[e_idx] <= 1'b1;
        end
    end

    // tag/target/jump payload is only meaningful under a set valid bit
    always_ff @(posedge clk) begin
        if (train_btb) begin
            btb_tag[e_idx]    <= PCE_i[31:IDX_W+2];
            btb_target[e_idx] <= PCTargetE_i;
            btb_is_j[e_idx]   <= !is_branch;
        end
    end

    for (genvar i = 0; i < PHT_N; i++) begin : g_pht
        localparam logic [G-1:0] ENTRY = G'(i);

        ucsbece154b_sat_counter2 u_ctr (
            .cnt      (pht[i]),
            .taken    (BranchTakenE_i),
            .next_cnt (pht_next[i])
        );

        // each counter trains only when Execute resolves a branch that indexed it
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pht[i] <= CTR_RESET;
            end else if (is_branch && (PHTaddrE_i == ENTRY)) begin
                pht[i] <= pht_next[i];
            end
        end
    end

    // zero-latency lookup; target is forced to 0 on a miss
    always_comb begin
        hit           = btb_valid[f_idx] && (btb_tag[f_idx] == pc_i[31:IDX_W+2]);
        BranchTaken_o = hit && (btb_is_j[f_idx] || pht[pht_idx_f][1]);
        BTBtarget_o   = hit ? btb_target[f_idx] : 32'd0;
        PHTaddr_o     = pht_idx_f;
    end

endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// tb/tb_ucsbece154b_branch_predictor.sv - scoreboard testbench for ucsbece154b_branch_predictor
module tb_ucsbece154b_branch_predictor;

`ifdef UCSBECE154B_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_i;
    logic        BranchTaken_o;
    logic [31:0] BTBtarget_o;
    logic [4:0]  PHTaddr_o;
    logic [6:0]  op_i;
    logic [31:0] PCE_i;
    logic [31:0] PCTargetE_i;
    logic [4:0]  PHTaddrE_i;
    logic        BranchTakenE_i;

    ucsbece154b_branch_predictor #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_i           (pc_i),
        .BranchTaken_o  (BranchTaken_o),
        .BTBtarget_o    (BTBtarget_o),
        .PHTaddr_o      (PHTaddr_o),
        .op_i           (op_i),
        .PCE_i          (PCE_i),
        .PCTargetE_i    (PCTargetE_i),
        .PHTaddrE_i     (PHTaddrE_i),
        .BranchTakenE_i (BranchTakenE_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  id;
        logic        taken;
        logic [31:0] tgt;
        logic [4:0]  pa;
    } pred_t;

    pred_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  last_taken;

    // reference state
    logic        m_valid [32];
    logic [24:0] m_tag   [32];
    logic [31:0] m_tgt   [32];
    logic        m_isj   [32];
    logic [1:0]  m_pht   [32];
    logic [4:0]  m_ghr;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_pht[i]   = 2'b01;
        end
        m_ghr = 5'd0;
    endtask

    function automatic logic [4:0] m_pidx(input logic [31:0] pc);
        return GSHARE ? (pc[6:2] ^ m_ghr) : pc[6:2];
    endfunction

    function automatic pred_t model_predict(input logic [31:0] pc, input logic [7:0] id);
        pred_t p;
        logic  h;
        h       = m_valid[pc[6:2]] && (m_tag[pc[6:2]] == pc[31:7]);
        p.id    = id;
        p.taken = h && (m_isj[pc[6:2]] || m_pht[m_pidx(pc)][1]);
        p.tgt   = h ? m_tgt[pc[6:2]] : 32'd0;
        p.pa    = m_pidx(pc);
        return p;
    endfunction

    // called at posedge+1; returns at the next posedge+1
    task automatic check(input logic [31:0] pc, input logic [7:0] id);
        pc_i = pc;
        exp_q.push_back(model_predict(pc, id));
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [6:0] op, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic tk);
        logic [4:0] pidx;
        pidx           = m_pidx(pc);
        op_i           = op;
        PCE_i          = pc;
        PCTargetE_i    = tgt;
        PHTaddrE_i     = pidx;
        BranchTakenE_i = tk;
        @(posedge clk);
        if (op == BR || op == JAL || op == JALR) begin
            m_valid[pc[6:2]] = 1'b1;
            m_tag[pc[6:2]]   = pc[31:7];
            m_tgt[pc[6:2]]   = tgt;
            m_isj[pc[6:2]]   = (op != BR);
        end
        if (op == BR) begin
            if (tk && m_pht[pidx] != 2'b11) m_pht[pidx] = m_pht[pidx] + 2'd1;
            if (!tk && m_pht[pidx] != 2'b00) m_pht[pidx] = m_pht[pidx] - 2'd1;
            if (GSHARE) m_ghr = {m_ghr[3:0], tk};
        end
        #1;
        op_i = 7'd0;
    endtask

    // monitor: compare every outstanding expectation against what the DUT shows
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            pred_t e;
            e = exp_q.pop_front();
            last_taken = BranchTaken_o;
            n_cmp++;
            if ({BranchTaken_o, BTBtarget_o, PHTaddr_o} !== {e.taken, e.tgt, e.pa}) begin
                n_err++;
                $display("FAIL pred%0d: got taken=%0b tgt=%h pa=%h, want taken=%0b tgt=%h pa=%h",
                         e.id, BranchTaken_o, BTBtarget_o, PHTaddr_o, e.taken, e.tgt, e.pa);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int miss8;
        reset = 1'b0; pc_i = 32'h0001_0010; op_i = 7'd0; PCE_i = '0;
        PCTargetE_i = '0; PHTaddrE_i = '0; BranchTakenE_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check(32'h0001_0010, 8'd1);
        reset = 1'b1;
        check(32'h0001_0010, 8'd2);

        // cold branch, then saturation up and back down
        train(BR, 32'h0001_0010, 32'h0001_0000, 1'b1);
        check(32'h0001_0010, 8'd3);
        for (int i = 0; i < 5; i++) train(BR, 32'h0001_0010, 32'h0001_0000, 1'b1);
        check(32'h0001_0010, 8'd4);
        train(BR, 32'h0001_0010, 32'h0001_0000, 1'b0);
        check(32'h0001_0010, 8'd5);
        train(BR, 32'h0001_0010, 32'h0001_0000, 1'b0);
        check(32'h0001_0010, 8'd6);

        // jal predicts taken irrespective of the counter
        train(BR,  32'h0001_0020, 32'h0001_0040, 1'b0);
        check(32'h0001_0020, 8'd7);
        train(JAL, 32'h0001_0020, 32'h0001_0040, 1'b1);
        check(32'h0001_0020, 8'd8);

        // aliasing BTB index evicts the older entry
        train(JALR, 32'h0001_0004, 32'h0002_0000, 1'b1);
        check(32'h0001_0004, 8'd9);
        train(JAL,  32'h0001_0084, 32'h0003_0000, 1'b1);
        check(32'h0001_0004, 8'd10);
        check(32'h0001_0084, 8'd11);

        // bubble changes nothing
        train(7'd0, 32'h0001_0010, 32'h0000_0000, 1'b1);
        check(32'h0001_0010, 8'd12);

        // asynchronous reset mid-cycle with BTB populated
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        pc_i = 32'h0001_0084;
        @(posedge clk); #1;
        check(32'h0001_0084, 8'd13);
        reset = 1'b1;
        check(32'h0001_0084, 8'd14);
        check(32'h0001_0020, 8'd15);

        // alternating pattern at one PC
        miss8 = 0;
        for (int i = 0; i < 16; i++) begin
            logic tk;
            tk = (i % 2 == 0);
            check(32'h0001_0100, 8'(20 + i));
            if (i >= 8 && last_taken != tk) miss8++;
            train(BR, 32'h0001_0100, 32'h0001_0200, tk);
        end
        n_cmp++;
        if (GSHARE ? (miss8 != 0) : (miss8 < 4)) begin
            n_err++;
            $display("FAIL alt_pattern: got %0d mispredicts in last 8, want %s",
                     miss8, GSHARE ? "0" : ">=4");
        end

        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked predictions, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
